dmem_arbiter: RTL

Two-port arbiter and sequencer placed in front of the single-port data memory (256 x 32-bit words, word-indexed by address bits [9:2], combinational read, write on clock edge). It lets the core load/store unit (M0) and a secondary master such as a DMA or debug port (M1) share the memory. Each cycle it grants at most one master, using round-robin with a bounded burst. It drives the memory control and address lines, rejects misaligned and out-of-range accesses, and returns a registered one-cycle response to the granted master.

---
 rtl/dmem_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin, burst-bounded arbiter in front of the
// single-port data memory, with address checking and registered responses.
module dmem_arbiter #(
  parameter int DEPTH     = 256,
  parameter int BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0]  BMAX    = 4'(BURST_MAX);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  logic        last_q, last_d;
  logic [3:0]  beat_q, beat_d;
  logic        m0_rvalid_q, m1_rvalid_q;
  logic [31:0] m0_rdata_q, m1_rdata_q;
  logic        m0_err_q, m1_err_q;

  logic        keep, g0, g1, any;
  logic        we, err;
  logic [31:0] addr, wdata, rdata_nxt;

  // Arbitration, address check and memory drive for the current cycle
  always_comb begin
    keep = (beat_q != 4'd0) && (beat_q < BMAX);
    g1   = m1_req && !rst
           && (!m0_req || (keep ? last_q : !last_q));
    g0   = m0_req && !rst && !g1;
    any  = g0 || g1;
    we    = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;
    if (g1) begin
      we    = m1_we;
      addr  = m1_addr;
      wdata = m1_wdata;
    end else if (g0) begin
      we    = m0_we;
      addr  = m0_addr;
      wdata = m0_wdata;
    end
    err       = (addr[1:0] != 2'b00) || (addr[31:2] >= DEPTH_W);
    mem_read  = any && !err && !we;
    mem_write = any && !err && we;
    mem_addr  = addr;
    mem_wdata = wdata;
    rdata_nxt = (!err && !we) ? mem_rdata : 32'd0;
  end

  // Owner and burst-length bookkeeping
  always_comb begin
    last_d = last_q;
    beat_d = beat_q;
    if (!any) begin
      beat_d = 4'd0;
    end else if (g1 == last_q) begin
      beat_d = (beat_q >= BMAX) ? BMAX : beat_q + 4'd1;
    end else begin
      last_d = g1;
      beat_d = 4'd1;
    end
  end

  // State and per-master response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= 1'b1;
      beat_q      <= 4'd0;
      m0_rvalid_q <= 1'b0;
      m0_rdata_q  <= 32'd0;
      m0_err_q    <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m1_rdata_q  <= 32'd0;
      m1_err_q    <= 1'b0;
    end else begin
      last_q      <= last_d;
      beat_q      <= beat_d;
      m0_rvalid_q <= g0;
      m0_rdata_q  <= g0 ? rdata_nxt : 32'd0;
      m0_err_q    <= g0 && err;
      m1_rvalid_q <= g1;
      m1_rdata_q  <= g1 ? rdata_nxt : 32'd0;
      m1_err_q    <= g1 && err;
    end
  end

  assign m0_gnt    = g0;
  assign m1_gnt    = g1;
  assign m0_rvalid = m0_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m0_err    = m0_err_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m1_rdata  = m1_rdata_q;
  assign m1_err    = m1_err_q;

endmodule
